// File: rtl/morse_disp_buf.sv
// morse_disp_buf
//   Feeder for the 8-digit scanning segment driver. Decoded Morse characters
//   arrive over a valid/ready handshake, are mapped to 7-segment glyphs and
//   shifted into an 8-slot display buffer presented as a 64-bit segment bus.
//
// Handshake: a character transfers on a rising clk edge where char_valid and
//   char_ready are both 1. char_ready is combinational and never depends on
//   char_valid. While char_ready is 0 the producer holds char_valid and
//   char_code stable.
//
// Parameters
//   SCROLL : 1 = an accept into a full buffer drops the oldest glyph,
//            0 = char_ready deasserts while the buffer is full
//   BLANK  : glyph loaded by reset/clear and shifted in by backspace
//
// Ports
//   clk        system clock
//   rst        asynchronous, active-high reset
//   char_valid char_code is valid this cycle
//   char_code  0-9 digits, 10-35 letters A-Z, 36 space, 37-63 invalid
//   char_ready block accepts char_code this cycle
//   clear      synchronous clear of buffer and count
//   backspace  remove the newest character
//   seg_data   [7:0] = slot 0 (newest) ... [63:56] = slot 7 (oldest)
//   count      characters held, 0..8
//   full       count == 8
//   err        one-cycle pulse after an invalid code is accepted

module morse_disp_buf #(
   parameter bit         SCROLL = 1'b1,
   parameter logic [7:0] BLANK  = 8'h00
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        char_valid,
   input  logic [5:0]  char_code,
   output logic        char_ready,
   input  logic        clear,
   input  logic        backspace,
   output logic [63:0] seg_data,
   output logic [3:0]  count,
   output logic        full,
   output logic        err
);

   logic [7:0] glyph;
   logic       accept;
   logic       invalid_code;

   // Segment order a,b,c,d,e,f,g,dp from bit 7 down to bit 0; dp never lit.
   always_comb begin
      glyph = 8'h02;
      case (char_code)
         6'd0:  glyph = 8'hFC;
         6'd1:  glyph = 8'h60;
         6'd2:  glyph = 8'hDA;
         6'd3:  glyph = 8'hF2;
         6'd4:  glyph = 8'h66;
         6'd5:  glyph = 8'hB6;
         6'd6:  glyph = 8'hBE;
         6'd7:  glyph = 8'hE0;
         6'd8:  glyph = 8'hFE;
         6'd9:  glyph = 8'hF6;
         6'd10: glyph = 8'hEE;
         6'd11: glyph = 8'h3E;
         6'd12: glyph = 8'h9C;
         6'd13: glyph = 8'h7A;
         6'd14: glyph = 8'h9E;
         6'd15: glyph = 8'h8E;
         6'd16: glyph = 8'hBC;
         6'd17: glyph = 8'h6E;
         6'd18: glyph = 8'h0C;
         6'd19: glyph = 8'h78;
         6'd20: glyph = 8'hAE;
         6'd21: glyph = 8'h1C;
         6'd22: glyph = 8'hA8;
         6'd23: glyph = 8'h2A;
         6'd24: glyph = 8'h3A;
         6'd25: glyph = 8'hCE;
         6'd26: glyph = 8'hE6;
         6'd27: glyph = 8'h0A;
         6'd28: glyph = 8'hB6;
         6'd29: glyph = 8'h1E;
         6'd30: glyph = 8'h7C;
         6'd31: glyph = 8'h38;
         6'd32: glyph = 8'h54;
         6'd33: glyph = 8'h6E;
         6'd34: glyph = 8'h76;
         6'd35: glyph = 8'hDA;
         6'd36: glyph = 8'h00;
         default: glyph = 8'h02; // dash for unassigned codes
      endcase
   end

   assign invalid_code = (char_code >= 6'd37);
   assign full         = (count == 4'd8);
   // clear and backspace take the edge, so no character may transfer with them.
   assign char_ready   = ~clear & ~backspace & (SCROLL | ~full);
   assign accept       = char_valid & char_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg_data <= {8{BLANK}};
         count    <= 4'd0;
         err      <= 1'b0;
      end else begin
         err <= accept & invalid_code;
         if (clear) begin
            seg_data <= {8{BLANK}};
            count    <= 4'd0;
         end else if (backspace) begin
            // Drop the newest glyph; older ones move down one slot.
            if (count != 4'd0) begin
               seg_data <= {BLANK, seg_data[63:8]};
               count    <= count - 4'd1;
            end
         end else if (accept) begin
            // In scroll mode a full buffer loses slot 7 off the top.
            seg_data <= {seg_data[55:0], glyph};
            if (count != 4'd8)
               count <= count + 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_morse_disp_buf.sv
// Testbench for morse_disp_buf. Two instances share stimulus: dut_s scrolls
// when full, dut_b blocks when full. A queue-of-glyphs reference model per
// instance predicts ready before each edge and the buffer state after it.

module tb_morse_disp_buf;

  typedef logic [7:0] byte_q_t[$];

  logic        clk;
  logic        rst;
  logic        char_valid;
  logic [5:0]  char_code;
  logic        clear;
  logic        backspace;

  logic        rdy_s, rdy_b;
  logic [63:0] seg_s, seg_b;
  logic [3:0]  cnt_s, cnt_b;
  logic        full_s, full_b;
  logic        err_s, err_b;

  int checks = 0;
  int errors = 0;

  // scoreboard queues: ready before the edge, state after the edge
  logic [1:0]   exp_rdy_q[$];
  logic [139:0] exp_q[$];

  // reference model contents, newest glyph at index 0
  byte_q_t mq_s;
  byte_q_t mq_b;

  logic [7:0] gtab [0:36] = '{
    8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6,
    8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E, 8'hBC, 8'h6E, 8'h0C, 8'h78,
    8'hAE, 8'h1C, 8'hA8, 8'h2A, 8'h3A, 8'hCE, 8'hE6, 8'h0A, 8'hB6, 8'h1E,
    8'h7C, 8'h38, 8'h54, 8'h6E, 8'h76, 8'hDA, 8'h00};

  morse_disp_buf #(.SCROLL(1'b1), .BLANK(8'h00)) dut_s (
    .clk(clk), .rst(rst), .char_valid(char_valid), .char_code(char_code),
    .char_ready(rdy_s), .clear(clear), .backspace(backspace),
    .seg_data(seg_s), .count(cnt_s), .full(full_s), .err(err_s));

  morse_disp_buf #(.SCROLL(1'b0), .BLANK(8'h00)) dut_b (
    .clk(clk), .rst(rst), .char_valid(char_valid), .char_code(char_code),
    .char_ready(rdy_b), .clear(clear), .backspace(backspace),
    .seg_data(seg_b), .count(cnt_b), .full(full_b), .err(err_b));

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] glyph_of(input logic [5:0] code);
    if (code <= 6'd36) return gtab[code];
    return 8'h02;
  endfunction

  function automatic logic [63:0] pack(input byte_q_t q);
    logic [63:0] s;
    s = '0;
    for (int i = 0; i < 8; i++)
      if (i < q.size()) s[i*8 +: 8] = q[i];
    return s;
  endfunction

  // One clock of the behavioural model for either buffer policy.
  task automatic model_cycle(input bit sc, input bit v, input bit cl, input bit bs,
                             input logic [5:0] code, output logic rdy,
                             output logic [69:0] st);
    byte_q_t q;
    logic e;
    q = sc ? mq_s : mq_b;
    rdy = !cl && !bs && (sc || q.size() < 8);
    e = 1'b0;
    if (cl) q.delete();
    else if (bs) begin
      if (q.size() > 0) void'(q.pop_front());
    end else if (v && rdy) begin
      q.push_front(glyph_of(code));
      if (q.size() > 8) void'(q.pop_back());
      e = (code >= 6'd37);
    end
    st = {e, (q.size() == 8), 4'(q.size()), pack(q)};
    if (sc) mq_s = q; else mq_b = q;
  endtask

  // Called at posedge+2: drives one cycle, predicts it, returns at next posedge+2.
  task automatic drive(input bit v, input logic [5:0] code, input bit cl, input bit bs);
    logic r_s, r_b;
    logic [69:0] st_s, st_b;
    char_valid = v;
    char_code  = code;
    clear      = cl;
    backspace  = bs;
    model_cycle(1'b1, v, cl, bs, code, r_s, st_s);
    model_cycle(1'b0, v, cl, bs, code, r_b, st_b);
    exp_rdy_q.push_back({r_s, r_b});
    exp_q.push_back({st_s, st_b});
    @(posedge clk);
    #2;
  endtask

  // ready monitor: combinational ready sampled mid-cycle
  initial begin
    logic [1:0] r;
    forever begin
      @(negedge clk);
      if (exp_rdy_q.size() > 0) begin
        r = exp_rdy_q.pop_front();
        chk("ready_s", {63'd0, rdy_s}, {63'd0, r[1]});
        chk("ready_b", {63'd0, rdy_b}, {63'd0, r[0]});
      end
    end
  end

  // state monitor: registered outputs sampled just after the edge
  initial begin
    logic [139:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("seg_s",   seg_s,             e[133:70]);
        chk("count_s", {60'd0, cnt_s},    {60'd0, e[137:134]});
        chk("full_s",  {63'd0, full_s},   {63'd0, e[138]});
        chk("err_s",   {63'd0, err_s},    {63'd0, e[139]});
        chk("seg_b",   seg_b,             e[63:0]);
        chk("count_b", {60'd0, cnt_b},    {60'd0, e[67:64]});
        chk("full_b",  {63'd0, full_b},   {63'd0, e[68]});
        chk("err_b",   {63'd0, err_b},    {63'd0, e[69]});
      end
    end
  end

  initial begin
    // reset
    rst = 1'b1;
    char_valid = 1'b0;
    char_code  = 6'd0;
    clear      = 1'b0;
    backspace  = 1'b0;
    #1;
    chk("rst_seg_s",   seg_s, 64'd0);
    chk("rst_count_s", {60'd0, cnt_s}, 64'd0);
    chk("rst_err_s",   {63'd0, err_s}, 64'd0);
    chk("rst_ready_s", {63'd0, rdy_s}, 64'd1);
    chk("rst_seg_b",   seg_b, 64'd0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;

    // three characters in a row
    drive(1, 6'd1, 0, 0);
    drive(1, 6'd2, 0, 0);
    drive(1, 6'd3, 0, 0);
    chk("abc_seg_s",   seg_s, 64'h0000_0000_0060_DAF2);
    chk("abc_count_s", {60'd0, cnt_s}, 64'd3);

    // scroll past full
    drive(0, 6'd0, 1, 0);
    for (int i = 0; i < 10; i++) drive(1, 6'(i), 0, 0);
    chk("scroll_seg_s",  seg_s, 64'hDAF2_66B6_BEE0_FEF6);
    chk("scroll_full_s", {63'd0, full_s}, 64'd1);
    chk("scroll_count_s", {60'd0, cnt_s}, 64'd8);

    // block when full, backspace opens one slot
    drive(0, 6'd0, 1, 0);
    for (int i = 0; i < 8; i++) drive(1, 6'd10, 0, 0);
    for (int i = 0; i < 3; i++) drive(1, 6'd11, 0, 0);
    chk("hold_seg_b", seg_b, 64'hEEEE_EEEE_EEEE_EEEE);
    drive(0, 6'd11, 0, 1);
    chk("bs_count_b", {60'd0, cnt_b}, 64'd7);
    chk("bs_slot7_b", {56'd0, seg_b[63:56]}, 64'd0);
    drive(1, 6'd11, 0, 0);
    chk("unblock_seg_b", seg_b, 64'hEEEE_EEEE_EEEE_EE3E);
    chk("unblock_count_b", {60'd0, cnt_b}, 64'd8);

    // clear beats backspace and accept
    drive(0, 6'd0, 1, 0);
    for (int i = 0; i < 4; i++) drive(1, 6'd20, 0, 0);
    drive(1, 6'd5, 1, 1);
    chk("prio_seg_s", seg_s, 64'd0);
    chk("prio_count_s", {60'd0, cnt_s}, 64'd0);
    drive(0, 6'd0, 0, 1);
    chk("bs_empty_count_s", {60'd0, cnt_s}, 64'd0);

    // invalid code and space
    drive(1, 6'd40, 0, 0);
    chk("inv_slot0_s", {56'd0, seg_s[7:0]}, 64'h02);
    chk("inv_err_s", {63'd0, err_s}, 64'd1);
    drive(1, 6'd36, 0, 0);
    chk("space_slot0_s", {56'd0, seg_s[7:0]}, 64'h00);
    chk("space_err_s", {63'd0, err_s}, 64'd0);

    // asynchronous reset mid-accept
    drive(0, 6'd0, 1, 0);
    for (int i = 0; i < 5; i++) drive(1, 6'd14, 0, 0);
    chk("pre_rst_count_s", {60'd0, cnt_s}, 64'd5);
    char_valid = 1'b1;
    char_code  = 6'd7;
    #1;
    rst = 1'b1;
    #1;
    chk("async_seg_s",   seg_s, 64'd0);
    chk("async_count_s", {60'd0, cnt_s}, 64'd0);
    chk("async_seg_b",   seg_b, 64'd0);
    chk("async_count_b", {60'd0, cnt_b}, 64'd0);
    mq_s.delete();
    mq_b.delete();
    char_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      bit v, cl, bs;
      logic [5:0] code;
      v    = ($urandom_range(0, 3) != 0);
      cl   = ($urandom_range(0, 24) == 0);
      bs   = ($urandom_range(0, 7) == 0);
      code = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(37, 63))
                                         : 6'($urandom_range(0, 36));
      drive(v, code, cl, bs);
    end

    drive(0, 6'd0, 0, 0);
    drive(0, 6'd0, 0, 0);
    chk("drain_exp_q", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // overall time bound
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
